// File: rtl/snake_pkg.sv
// Shared constants, cell type, FSM states and small helpers for the snake VGA renderer.
package snake_pkg;

   localparam logic [1:0]  PIX_DIV_LAST = 2'd3;   // four clk per pixel

   localparam logic [9:0]  H_ACTIVE     = 10'd640;
   localparam logic [9:0]  H_FP         = 10'd16;
   localparam logic [9:0]  H_SYNC       = 10'd96;
   localparam logic [9:0]  H_BP         = 10'd48;
   localparam logic [9:0]  H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam logic [9:0]  H_SYNC_START = H_ACTIVE + H_FP;
   localparam logic [9:0]  H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

   localparam logic [9:0]  V_ACTIVE     = 10'd480;
   localparam logic [9:0]  V_FP         = 10'd10;
   localparam logic [9:0]  V_SYNC       = 10'd2;
   localparam logic [9:0]  V_BP         = 10'd33;
   localparam logic [9:0]  V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0]  V_SYNC_START = V_ACTIVE + V_FP;
   localparam logic [9:0]  V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

   localparam logic [3:0]  CELL_LAST    = 4'd9;
   localparam int          GRID_W       = 64;
   localparam int          GRID_H       = 48;
   localparam int          MAX_LEN      = 32;
   localparam logic [5:0]  COL_LAST     = 6'd63;
   localparam logic [5:0]  ROW_LAST     = 6'd47;
   localparam logic [5:0]  LEN_MAX      = 6'd32;

   localparam logic [11:0] BLANK_COLOR  = 12'h000;
   localparam logic [11:0] BG_COLOR     = 12'h000;
   localparam logic [11:0] SNAKE_COLOR  = 12'h0F0;
   localparam logic [11:0] BORDER_COLOR = 12'hF00;

   typedef struct packed {
      logic [5:0] x;
      logic [5:0] y;
   } cell_t;

   typedef enum logic [1:0] {
      ST_CLEAR    = 2'd0,
      ST_IDLE     = 2'd1,
      ST_CLR_TAIL = 2'd2,
      ST_SET_HEAD = 2'd3
   } state_e;

   function automatic logic in_grid(input cell_t c);
      return (c.y <= ROW_LAST);
   endfunction

   function automatic logic is_border(input cell_t c);
      return (c.x == 6'd0) || (c.x == COL_LAST) || (c.y == 6'd0) || (c.y == ROW_LAST);
   endfunction

endpackage

// File: rtl/snake_vga_render_vga_timing.sv
// 640x480@60 raster generator: pixel tick, h/v counters, cell coordinates by
// sub-counter carry, and combinational sync/active decoded from the counters.
module vga_timing
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic [5:0] cx,
   output logic [5:0] cy,
   output logic       hsync,
   output logic       vsync,
   output logic       active
);

   logic [1:0] div_r;
   logic [9:0] h_r, v_r;
   logic [3:0] sub_x_r, sub_y_r;
   logic [5:0] cx_r, cy_r;
   logic       tick_s, h_wrap_s, v_wrap_s;

   assign tick_s   = (div_r == PIX_DIV_LAST);
   assign h_wrap_s = (h_r == H_TOTAL - 10'd1);
   assign v_wrap_s = (v_r == V_TOTAL - 10'd1);

   // Pixel clock divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= 2'd0;
      end else if (tick_s) begin
         div_r <= 2'd0;
      end else begin
         div_r <= div_r + 2'd1;
      end
   end

   // Raster position and cell coordinates, advanced once per pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_r     <= 10'd0;
         v_r     <= 10'd0;
         sub_x_r <= 4'd0;
         sub_y_r <= 4'd0;
         cx_r    <= 6'd0;
         cy_r    <= 6'd0;
      end else if (tick_s) begin
         if (h_wrap_s) begin
            h_r     <= 10'd0;
            sub_x_r <= 4'd0;
            cx_r    <= 6'd0;
            if (v_wrap_s) begin
               v_r     <= 10'd0;
               sub_y_r <= 4'd0;
               cy_r    <= 6'd0;
            end else begin
               v_r <= v_r + 10'd1;
               if (sub_y_r == CELL_LAST) begin
                  sub_y_r <= 4'd0;
                  cy_r    <= cy_r + 6'd1;
               end else begin
                  sub_y_r <= sub_y_r + 4'd1;
               end
            end
         end else begin
            h_r <= h_r + 10'd1;
            if (sub_x_r == CELL_LAST) begin
               sub_x_r <= 4'd0;
               cx_r    <= cx_r + 6'd1;
            end else begin
               sub_x_r <= sub_x_r + 4'd1;
            end
         end
      end
   end

   assign pix_tick = tick_s;
   assign cx       = cx_r;
   assign cy       = cy_r;
   assign hsync    = !((h_r >= H_SYNC_START) && (h_r <= H_SYNC_END));
   assign vsync    = !((v_r >= V_SYNC_START) && (v_r <= V_SYNC_END));
   assign active   = (h_r < H_ACTIVE) && (v_r < V_ACTIVE);

endmodule

// File: rtl/snake_vga_render.sv
// Snake body tracker and VGA renderer: occupancy bitmap, body FIFO and update FSM.
// Build macro SNAKE_BORDER_EN adds a red, lethal border ring of cells.
module snake_vga_render
   import snake_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        step_valid,
   output logic        step_ready,
   input  logic [5:0]  head_x,
   input  logic [5:0]  head_y,
   input  logic        grow,
   output logic        collide,
   output logic [5:0]  length,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb
);

   state_e            state_r, state_s;
   cell_t             head_r, tail_s, scan_cell_s;
   cell_t             fifo_r [MAX_LEN];
   logic [GRID_W-1:0] bitmap_r [GRID_H];
   logic [4:0]        wr_ptr_r, rd_ptr_r;
   logic [5:0]        length_r, clr_row_r;
   logic              step_ready_r, collide_r, hsync_r, vsync_r;
   logic [11:0]       rgb_r, pix_color_s;
   logic              accept_s, grow_eff_s, in_grid_s, border_s, hit_s;
   logic              write_ok_s, head_collide_s;
   logic              pix_tick_s, t_hsync_s, t_vsync_s, active_s;
   logic [5:0]        cx_s, cy_s;

   vga_timing u_timing (
      .clk      (clk),
      .rst_n    (rst_n),
      .pix_tick (pix_tick_s),
      .cx       (cx_s),
      .cy       (cy_s),
      .hsync    (t_hsync_s),
      .vsync    (t_vsync_s),
      .active   (active_s)
   );

   assign tail_s     = fifo_r[rd_ptr_r];
   assign grow_eff_s = grow && (length_r < LEN_MAX);

   // Update FSM next state; clear beats a simultaneous step in IDLE.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            if ((clr_row_r == ROW_LAST) && !clear) state_s = ST_IDLE;
            else                                   state_s = ST_CLEAR;
         end
         ST_IDLE: begin
            if (clear) begin
               state_s = ST_CLEAR;
            end else if (step_valid) begin
               accept_s = 1'b1;
               if (!grow_eff_s && (length_r != 6'd0)) state_s = ST_CLR_TAIL;
               else                                   state_s = ST_SET_HEAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLR_TAIL: begin
            if (clear) state_s = ST_CLEAR;
            else       state_s = ST_SET_HEAD;
         end
         ST_SET_HEAD: begin
            if (clear) state_s = ST_CLEAR;
            else       state_s = ST_IDLE;
         end
         default: state_s = ST_CLEAR;
      endcase
   end

   // Head cell evaluation for SET_HEAD: occupancy, border and write permission.
   always_comb begin
      in_grid_s = in_grid(head_r);
`ifdef SNAKE_BORDER_EN
      border_s  = is_border(head_r);
`else
      border_s  = 1'b0;
`endif
      if (in_grid_s) hit_s = bitmap_r[head_r.y][head_r.x];
      else           hit_s = 1'b0;
      write_ok_s     = in_grid_s && !border_s;
      head_collide_s = (in_grid_s && border_s) || (write_ok_s && hit_s);
   end

   // FSM state, handshake, FIFO pointers and length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_CLEAR;
         step_ready_r <= 1'b0;
         collide_r    <= 1'b0;
         head_r       <= 12'd0;
         wr_ptr_r     <= 5'd0;
         rd_ptr_r     <= 5'd0;
         length_r     <= 6'd0;
         clr_row_r    <= 6'd0;
      end else begin
         state_r      <= state_s;
         step_ready_r <= (state_s == ST_IDLE);
         collide_r    <= (state_r == ST_SET_HEAD) && head_collide_s;
         case (state_r)
            ST_CLEAR: begin
               wr_ptr_r  <= 5'd0;
               rd_ptr_r  <= 5'd0;
               length_r  <= 6'd0;
               clr_row_r <= (clr_row_r == ROW_LAST) ? 6'd0 : clr_row_r + 6'd1;
            end
            ST_IDLE: begin
               clr_row_r <= 6'd0;
               if (accept_s) head_r <= {head_x, head_y};
            end
            ST_CLR_TAIL: begin
               rd_ptr_r <= rd_ptr_r + 5'd1;
               length_r <= length_r - 6'd1;
            end
            ST_SET_HEAD: begin
               if (write_ok_s) begin
                  wr_ptr_r <= wr_ptr_r + 5'd1;
                  length_r <= length_r + 6'd1;
               end
            end
            default: clr_row_r <= 6'd0;
         endcase
      end
   end

   // Bitmap single write port: row wipe, tail clear or head set.
   always_ff @(posedge clk) begin
      case (state_r)
         ST_CLEAR:    bitmap_r[clr_row_r] <= '0;
         ST_CLR_TAIL: bitmap_r[tail_s.y][tail_s.x] <= 1'b0;
         ST_SET_HEAD: begin
            if (write_ok_s) bitmap_r[head_r.y][head_r.x] <= 1'b1;
         end
         default: ;
      endcase
   end

   // Body FIFO storage, pushed when a head is written.
   always_ff @(posedge clk) begin
      if ((state_r == ST_SET_HEAD) && write_ok_s) fifo_r[wr_ptr_r] <= head_r;
   end

   // Pixel colour from the bitmap read port at the current raster cell.
   always_comb begin
      scan_cell_s = {cx_s, cy_s};
      if (!active_s) begin
         pix_color_s = BLANK_COLOR;
`ifdef SNAKE_BORDER_EN
      end else if (is_border(scan_cell_s)) begin
         pix_color_s = BORDER_COLOR;
`endif
      end else if (bitmap_r[scan_cell_s.y][scan_cell_s.x]) begin
         pix_color_s = SNAKE_COLOR;
      end else begin
         pix_color_s = BG_COLOR;
      end
   end

   // Video outputs, one pixel behind the raster counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_r <= 1'b1;
         vsync_r <= 1'b1;
         rgb_r   <= 12'h000;
      end else if (pix_tick_s) begin
         hsync_r <= t_hsync_s;
         vsync_r <= t_vsync_s;
         rgb_r   <= pix_color_s;
      end
   end

   assign step_ready = step_ready_r;
   assign collide    = collide_r;
   assign length     = length_r;
   assign hsync      = hsync_r;
   assign vsync      = vsync_r;
   assign rgb        = rgb_r;

endmodule
